// File: rtl/cache_control_pkg.sv
// cache_control_pkg: cache address field types and controller state encoding.
package cache_control_pkg;
  typedef logic [8:0] lc3b_c_tag;
  typedef logic [2:0] lc3b_c_index;
  typedef logic [2:0] lc3b_c_offset;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_t;
endpackage

// File: rtl/cache_control_if.sv
// cache_control_if: CPU port, cache datapath, physical memory and counter signals of the controller.
interface cache_control_if import cache_control_pkg::*; #(parameter int CNT_WIDTH = 16);
  logic mem_read, mem_write, mem_resp;
  logic [1:0] mem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic dp_hit, dp_victim_dirty, dp_write_enable, dp_control_load;
  lc3b_c_tag dp_victim_tag;
  logic [127:0] dp_line_out, dp_line_in;
  logic pmem_read, pmem_write, pmem_resp;
  logic [15:0] pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic clear_counters;
  logic [CNT_WIDTH-1:0] hit_count, miss_count, wb_count;
  modport slave (
    input mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input dp_hit, dp_victim_dirty, dp_victim_tag, dp_line_out, pmem_rdata, pmem_resp, clear_counters,
    output mem_rdata, mem_resp, dp_line_in, dp_write_enable, dp_control_load,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, hit_count, miss_count, wb_count
  );
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output dp_hit, dp_victim_dirty, dp_victim_tag, dp_line_out, pmem_rdata, pmem_resp, clear_counters,
    input mem_rdata, mem_resp, dp_line_in, dp_write_enable, dp_control_load,
    input pmem_read, pmem_write, pmem_address, pmem_wdata, hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_control_line_merge.sv
// cache_line_merge: inserts the enabled byte lanes of a store word into a 128-bit line.
module cache_line_merge import cache_control_pkg::*; (
  input  logic [127:0] i_line,
  input  lc3b_c_offset i_off,
  input  logic [1:0]   i_be,
  input  logic [15:0]  i_wdata,
  output logic [127:0] o_line
);
  logic [6:0] w_base;
  assign w_base = {i_off, 4'h0};
  always_comb begin
    o_line = i_line;
    if (i_be[0]) o_line[w_base +: 8] = i_wdata[7:0];
    if (i_be[1]) o_line[w_base + 7'd8 +: 8] = i_wdata[15:8];
  end
endmodule

// File: rtl/cache_control.sv
// cache_control: sequences hit service, dirty writeback and line allocate for a 2-way 8-set cache.
module cache_control import cache_control_pkg::*; #(parameter int CNT_WIDTH = 16) (
  input logic clk,
  input logic reset,
  cache_control_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  cache_state_t r_state;
  logic r_refill;
  logic [CNT_WIDTH-1:0] r_hit, r_miss, r_wb;
  logic [127:0] w_merged;
  logic w_cmp_hit, w_cmp_miss, w_wb_done, w_alloc, w_unused;
  cache_line_merge u_merge (
    .i_line(bus.dp_line_out),
    .i_off(bus.mem_address[3:1]),
    .i_be(bus.mem_byte_enable),
    .i_wdata(bus.mem_wdata),
    .o_line(w_merged)
  );
  assign w_unused = bus.mem_address[0];
  assign w_cmp_hit = r_state == COMPARE && bus.dp_hit;
  assign w_cmp_miss = r_state == COMPARE && !bus.dp_hit;
  assign w_wb_done = r_state == WRITEBACK && bus.pmem_resp;
  assign w_alloc = r_state == ALLOCATE;
  always_comb begin
    bus.mem_resp = w_cmp_hit;
    bus.mem_rdata = w_cmp_hit ? bus.dp_line_out[{bus.mem_address[3:1], 4'h0} +: 16] : 16'h0;
    bus.dp_write_enable = w_cmp_hit && bus.mem_write && |bus.mem_byte_enable;
    bus.dp_control_load = w_alloc && bus.pmem_resp;
    bus.dp_line_in = w_alloc ? bus.pmem_rdata : w_merged;
    bus.pmem_write = r_state == WRITEBACK;
    bus.pmem_read = w_alloc;
    bus.pmem_address = r_state == WRITEBACK ? {bus.dp_victim_tag, bus.mem_address[6:4], 4'h0}
                     : w_alloc ? {bus.mem_address[15:4], 4'h0} : 16'h0;
  end
  assign bus.pmem_wdata = bus.dp_line_out;
  assign bus.hit_count = r_hit;
  assign bus.miss_count = r_miss;
  assign bus.wb_count = r_wb;
  // r_refill marks the re-compare that follows a fill, which must not count as a hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_refill <= 1'b0;
    end else begin
      r_refill <= w_alloc;
      r_state <= r_state == IDLE ? ((bus.mem_read | bus.mem_write) ? COMPARE : IDLE)
               : r_state == COMPARE ? (bus.dp_hit ? IDLE : bus.dp_victim_dirty ? WRITEBACK : ALLOCATE)
               : bus.pmem_resp ? (r_state == WRITEBACK ? ALLOCATE : COMPARE) : r_state;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit <= '0;
      r_miss <= '0;
      r_wb <= '0;
    end else begin
      r_hit <= bus.clear_counters ? '0 : (w_cmp_hit && !r_refill && r_hit != MAX) ? r_hit + CNT_WIDTH'(1) : r_hit;
      r_miss <= bus.clear_counters ? '0 : (w_cmp_miss && r_miss != MAX) ? r_miss + CNT_WIDTH'(1) : r_miss;
      r_wb <= bus.clear_counters ? '0 : (w_wb_done && r_wb != MAX) ? r_wb + CNT_WIDTH'(1) : r_wb;
    end
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized scoreboard bench with flat-memory reference, datapath and pmem models.
module tb_cache_control;
  import cache_control_pkg::*;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  cache_control_if #(.CNT_WIDTH(16)) bus();
  cache_control_if #(.CNT_WIDTH(2)) sbus();
  cache_control #(.CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  cache_control #(.CNT_WIDTH(2)) sdut (.clk(clk), .reset(reset), .bus(sbus));

  int n_chk = 0, n_pass = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0, we_cnt = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [15:0] ref_mem [logic [14:0]];
  logic [127:0] pm [logic [11:0]];
  function automatic logic [15:0] init_word(input logic [14:0] w);
    return 16'({1'b0, w} * 16'h9E37) ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] ref_rd(input logic [14:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction
  function automatic logic [127:0] pm_line(input logic [11:0] l);
    logic [127:0] v;
    if (pm.exists(l)) return pm[l];
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = init_word({l, 3'(k)});
    return v;
  endfunction

  bit dv [8][2], dd [8][2], lru [8];
  bit [8:0] dt [8][2];
  bit [127:0] dl [8][2];
  logic [2:0] m_idx;
  lc3b_c_tag m_tag;
  logic m_hit, m_hw;
  always_comb begin
    m_idx = bus.mem_address[6:4];
    m_tag = bus.mem_address[15:7];
    m_hit = 0;
    m_hw = 0;
    for (int w = 0; w < 2; w++) if (dv[m_idx][w] && dt[m_idx][w] == m_tag) begin m_hit = 1; m_hw = w[0]; end
    bus.dp_hit = m_hit;
    bus.dp_line_out = dl[m_idx][m_hit ? m_hw : lru[m_idx]];
    bus.dp_victim_dirty = dv[m_idx][lru[m_idx]] && dd[m_idx][lru[m_idx]];
    bus.dp_victim_tag = dt[m_idx][lru[m_idx]];
  end
  always @(posedge clk) begin
    if (bus.dp_write_enable) begin dl[m_idx][m_hw] <= bus.dp_line_in; dd[m_idx][m_hw] <= 1; end
    if (bus.dp_control_load) begin
      dl[m_idx][lru[m_idx]] <= bus.dp_line_in;
      dv[m_idx][lru[m_idx]] <= 1;
      dt[m_idx][lru[m_idx]] <= m_tag;
      dd[m_idx][lru[m_idx]] <= 0;
    end
    if (bus.mem_resp) lru[m_idx] <= ~m_hw;
  end

  typedef struct {logic wr; logic [15:0] a;} op_t;
  op_t pm_log[$];
  bit stall = 0, late = 0;
  initial begin
    bus.pmem_resp = 0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (stall) bus.pmem_resp = late;
      else if (bus.pmem_read || bus.pmem_write) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        chk("pmem_exclusive", 128'(bus.pmem_read & bus.pmem_write), 128'(0));
        chk("pmem_align", 128'(bus.pmem_address[3:0]), 128'(0));
        if (bus.pmem_write) begin
          chk("wb_addr", 128'(bus.pmem_address), 128'({bus.dp_victim_tag, bus.mem_address[6:4], 4'h0}));
          chk("wb_data", bus.pmem_wdata, bus.dp_line_out);
          pm[bus.pmem_address[15:4]] = bus.pmem_wdata;
          pm_log.push_back('{1'b1, bus.pmem_address});
        end else begin
          chk("fill_addr", 128'(bus.pmem_address), 128'({bus.mem_address[15:4], 4'h0}));
          bus.pmem_rdata = pm_line(bus.pmem_address[15:4]);
          pm_log.push_back('{1'b0, bus.pmem_address});
        end
        bus.pmem_resp = 1;
        @(posedge clk); #1;
        bus.pmem_resp = 0;
      end
    end
  end

  typedef struct {logic rd; logic [15:0] data; logic we;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  always @(negedge clk) begin
    if (bus.dp_write_enable) we_cnt++;
    if (!reset && bus.mem_resp) begin
      if (sb.size() == 0) chk("unexpected_resp", 128'(bus.mem_resp), 128'(0));
      else begin
        m_e = sb.pop_front();
        if (m_e.rd) chk("rdata", 128'(bus.mem_rdata), 128'(m_e.data));
        chk("write_enable", 128'(bus.dp_write_enable), 128'(m_e.we));
      end
    end
  end

  task automatic chk_counts();
    chk("hit_count", 128'(bus.hit_count), 128'(exp_hit));
    chk("miss_count", 128'(bus.miss_count), 128'(exp_miss));
    chk("wb_count", 128'(bus.wb_count), 128'(exp_wb));
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
    exp_t e;
    logic [15:0] nw;
    logic was_hit;
    int lat;
    @(posedge clk); #1;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a; bus.mem_byte_enable = be; bus.mem_wdata = wd;
    #1;
    was_hit = bus.dp_hit;
    if (was_hit) exp_hit++;
    else begin exp_miss++; if (bus.dp_victim_dirty) exp_wb++; end
    e.rd = !wr;
    e.data = ref_rd(a[15:1]);
    e.we = wr && be != 2'b00;
    if (wr) begin
      nw = ref_rd(a[15:1]);
      if (be[0]) nw[7:0] = wd[7:0];
      if (be[1]) nw[15:8] = wd[15:8];
      ref_mem[a[15:1]] = nw;
    end
    sb.push_back(e);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.mem_resp && lat < 400);
    if (!bus.mem_resp) chk("resp_timeout", 128'(bus.mem_resp), 128'(1));
    if (was_hit) chk("hit_latency", 128'(lat), 128'(2));
    @(posedge clk); #1;
    bus.mem_read = 0; bus.mem_write = 0;
    chk_counts();
  endtask

  task automatic s_hit();
    int n = 0;
    @(posedge clk); #1 sbus.mem_read = 1;
    do begin @(negedge clk); n++; end while (!sbus.mem_resp && n < 50);
    chk("small_resp", 128'(sbus.mem_resp), 128'(1));
    @(posedge clk); #1 sbus.mem_read = 0;
  endtask

  logic [127:0] v;
  logic [8:0] tags [4] = '{9'h024, 9'h044, 9'h088, 9'h0C8};
  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte_enable = 0; bus.mem_address = 0; bus.mem_wdata = 0;
    bus.clear_counters = 0;
    sbus.mem_read = 0; sbus.mem_write = 0; sbus.mem_byte_enable = 0; sbus.mem_address = 0; sbus.mem_wdata = 0;
    sbus.clear_counters = 0; sbus.dp_hit = 1; sbus.dp_victim_dirty = 0; sbus.dp_victim_tag = 0;
    sbus.dp_line_out = '0; sbus.pmem_rdata = '0; sbus.pmem_resp = 0;
    v = pm_line(12'h123); v[47:32] = 16'hBEEF; pm[12'h123] = v; ref_mem[15'h091A] = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_pmem_rw", 128'({bus.pmem_read, bus.pmem_write, bus.mem_resp, bus.dp_write_enable, bus.dp_control_load}), 128'(0));
    chk("rst_pmem_addr", 128'(bus.pmem_address), 128'(0));
    chk_counts();
    @(posedge clk); #1 reset = 0;

    pm_log.delete();
    do_req(1, 0, 16'h1234, 2'b00, 16'h0);
    chk("cold_ops", 128'(pm_log.size()), 128'(1));
    if (pm_log.size() == 1) chk("cold_fill", 128'({pm_log[0].wr, pm_log[0].a}), 128'({1'b0, 16'h1230}));
    chk("cold_hits", 128'(bus.hit_count), 128'(0));
    chk("cold_misses", 128'(bus.miss_count), 128'(1));
    pm_log.delete();
    do_req(1, 0, 16'h1236, 2'b00, 16'h0);
    chk("hit_no_pmem", 128'(pm_log.size()), 128'(0));
    chk("hit_one", 128'(bus.hit_count), 128'(1));
    we_cnt = 0;
    do_req(0, 1, 16'h1235, 2'b10, 16'hAA55);
    chk("we_pulses", 128'(we_cnt), 128'(1));
    v[47:32] = 16'hAAEF;
    chk("merged_line", dl[3][0], v);
    do_req(1, 0, 16'h2230, 2'b00, 16'h0);
    pm_log.delete();
    do_req(1, 0, 16'h4430, 2'b00, 16'h0);
    chk("dirty_ops", 128'(pm_log.size()), 128'(2));
    if (pm_log.size() == 2) begin
      chk("dirty_wb", 128'({pm_log[0].wr, pm_log[0].a}), 128'({1'b1, 16'h1230}));
      chk("dirty_fill", 128'({pm_log[1].wr, pm_log[1].a}), 128'({1'b0, 16'h4430}));
    end
    chk("dirty_wbcnt", 128'(bus.wb_count), 128'(1));

    do_req(0, 1, 16'h2230, 2'b11, 16'h1357);
    do_req(1, 0, 16'h4430, 2'b00, 16'h0);
    stall = 1;
    @(posedge clk); #1;
    bus.mem_read = 1; bus.mem_address = 16'h6430;
    repeat (4) @(negedge clk);
    chk("wb_pending", 128'(bus.pmem_write), 128'(1));
    #2 reset = 1;
    #1;
    chk("rst_drops_write", 128'(bus.pmem_write), 128'(0));
    chk("rst_no_resp", 128'(bus.mem_resp), 128'(0));
    bus.mem_read = 0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk) late = 1;
    @(negedge clk) late = 0;
    repeat (3) begin @(negedge clk); chk("late_resp_ignored", 128'({bus.mem_resp, bus.pmem_write, bus.pmem_read}), 128'(0)); end
    chk_counts();
    stall = 0;

    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      int op;
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      op = $urandom_range(0, 3);
      do_req(op != 2, op >= 2, a, 2'($urandom_range(0, 3)), 16'($urandom));
    end

    repeat (5) s_hit();
    chk("sat_hit", 128'(sbus.hit_count), 128'(3));
    chk("sat_miss", 128'(sbus.miss_count), 128'(0));
    @(posedge clk); #1 sbus.mem_read = 1;
    @(posedge clk); #1 sbus.clear_counters = 1;
    @(negedge clk) chk("clear_hit_resp", 128'(sbus.mem_resp), 128'(1));
    @(posedge clk); #1 sbus.clear_counters = 0; sbus.mem_read = 0;
    chk("clear_wins", 128'(sbus.hit_count), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
